card_dealer: RTL and testbench

Deals cards without repetition from a single 52-card deck for the blackjack datapath. A free-running counter's `value` output is the seed. On each deal request the block maps the seed to a deck index and probes linearly, one slot per cycle, for an undealt card. It then returns the card's rank, suit and blackjack points with a one-cycle valid pulse. It sits between the free-running counter (upstream) and the player/dealer hand-scoring logic (downstream).

---
 rtl/blackjack_pkg.sv | 25 ++
 rtl/card_decode.sv | 32 +++
 rtl/card_dealer.sv | 105 ++++++++++
 tb/tb_card_dealer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared card types and constants for the blackjack datapath.
package blackjack_pkg;

  localparam int DECK_SIZE = 52;
  localparam int SUITS     = 4;
  localparam int RANKS     = 13;

  typedef logic [5:0] card_idx_t;
  typedef logic [3:0] rank_t;
  typedef logic [1:0] suit_t;
  typedef logic [3:0] points_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DEAL   = 2'd2
  } dealer_state_t;

  // Fold a 6-bit seed slice into 0..51 (52..63 map onto 0..11).
  function automatic card_idx_t fold_seed(input logic [5:0] s);
    if (s >= 6'(DECK_SIZE)) return s - 6'(DECK_SIZE);
    else                    return s;
  endfunction

endpackage

// File: rtl/card_decode.sv
// Combinational deck index -> rank / suit / blackjack points.
// Suit and rank come from a constant compare/subtract chain, no divider.
module card_decode
  import blackjack_pkg::*;
(
  input  logic [5:0] idx,
  output logic [3:0] rank,
  output logic [1:0] suit,
  output logic [3:0] points
);

  logic [5:0] rem;

  // Strip whole suits of 13 off the index, then derive rank and points.
  always_comb begin
    rem  = idx;
    suit = 2'd0;
    if (idx >= 6'(3*RANKS)) begin
      suit = 2'd3;
      rem  = idx - 6'(3*RANKS);
    end else if (idx >= 6'(2*RANKS)) begin
      suit = 2'd2;
      rem  = idx - 6'(2*RANKS);
    end else if (idx >= 6'(RANKS)) begin
      suit = 2'd1;
      rem  = idx - 6'(RANKS);
    end
    rank   = rem[3:0] + 4'd1;
    points = (rank > 4'd10) ? 4'd10 : rank;
  end

endmodule

// File: rtl/card_dealer.sv
// Deals cards without repetition from one 52-card deck. The seed picks a
// start slot; a linear probe walks one slot per cycle to an undealt card.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int DECK_SIZE = 52,
  parameter int SEED_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shuffle,
  input  logic [SEED_W-1:0] seed,
  input  logic              deal_req,
  output logic              card_valid,
  output logic [3:0]        card_rank,
  output logic [1:0]        card_suit,
  output logic [3:0]        card_points,
  output logic              busy,
  output logic              deck_empty,
  output logic [5:0]        cards_left,
  output logic              deal_err
);

  localparam logic [5:0] FULL = 6'(DECK_SIZE);
  localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);

  dealer_state_t        state;
  logic [DECK_SIZE-1:0] dealt;
  card_idx_t            probe;
  card_idx_t            start_idx;
  rank_t                dec_rank;
  suit_t                dec_suit;
  points_t              dec_points;
  logic                 unused_seed_hi;

  // Only the low six seed bits pick the start slot.
  assign start_idx      = fold_seed(seed[5:0]);
  assign unused_seed_hi = ^seed[SEED_W-1:6];

  card_decode u_decode (
    .idx    (probe),
    .rank   (dec_rank),
    .suit   (dec_suit),
    .points (dec_points)
  );

  // Dealer FSM: shuffle overrides everything; busy stays up through the
  // card_valid cycle so a request there is ignored rather than accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dealt       <= '0;
      probe       <= '0;
      cards_left  <= FULL;
      deck_empty  <= 1'b0;
      busy        <= 1'b0;
      card_valid  <= 1'b0;
      deal_err    <= 1'b0;
      card_rank   <= '0;
      card_suit   <= '0;
      card_points <= '0;
    end else begin
      card_valid <= 1'b0;
      deal_err   <= 1'b0;
      if (shuffle) begin
        state      <= IDLE;
        dealt      <= '0;
        cards_left <= FULL;
        deck_empty <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
            if (deal_req && !busy) begin
              if (cards_left == '0) begin
                deal_err <= 1'b1;
              end else begin
                probe <= start_idx;
                busy  <= 1'b1;
                state <= SEARCH;
              end
            end
          end
          SEARCH: begin
            if (!dealt[probe]) state <= DEAL;
            else               probe <= (probe == LAST) ? '0 : probe + 6'd1;
          end
          DEAL: begin
            dealt[probe] <= 1'b1;
            cards_left   <= cards_left - 6'd1;
            deck_empty   <= (cards_left == 6'd1);
            card_rank    <= dec_rank;
            card_suit    <= dec_suit;
            card_points  <= dec_points;
            card_valid   <= 1'b1;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: deals, collisions, wrap, exhaustion,
// shuffle aborts and asynchronous reset mid-search.
module tb_card_dealer;

  logic        clk = 1'b0;
  logic        reset;
  logic        shuffle;
  logic [15:0] seed;
  logic        deal_req;
  logic        card_valid;
  logic [3:0]  card_rank;
  logic [1:0]  card_suit;
  logic [3:0]  card_points;
  logic        busy;
  logic        deck_empty;
  logic [5:0]  cards_left;
  logic        deal_err;

  int n_assert = 0;
  int n_fail   = 0;

  card_dealer #(.DECK_SIZE(52), .SEED_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .shuffle     (shuffle),
    .seed        (seed),
    .deal_req    (deal_req),
    .card_valid  (card_valid),
    .card_rank   (card_rank),
    .card_suit   (card_suit),
    .card_points (card_points),
    .busy        (busy),
    .deck_empty  (deck_empty),
    .cards_left  (cards_left),
    .deal_err    (deal_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request (called at a negedge), wait for card_valid, check it.
  task automatic deal(input logic [15:0] s, input int e_rank, input int e_suit,
                      input int e_pts, input int e_lat, input int e_left,
                      input string tag);
    int e;
    seed     = s;
    deal_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    deal_req = 1'b0;
    chk({tag, " busy_rise"}, int'(busy), 1);
    e = 0;
    while (!card_valid && e < 80) begin
      @(posedge clk);
      @(negedge clk);
      e++;
    end
    chk({tag, " latency"}, e, e_lat);
    chk({tag, " rank"}, int'(card_rank), e_rank);
    chk({tag, " suit"}, int'(card_suit), e_suit);
    chk({tag, " points"}, int'(card_points), e_pts);
    chk({tag, " cards_left"}, int'(cards_left), e_left);
    chk({tag, " deck_empty"}, int'(deck_empty), (e_left == 0) ? 1 : 0);
    chk({tag, " busy_in_valid"}, int'(busy), 1);
    @(negedge clk);
    chk({tag, " valid_pulse"}, int'(card_valid), 0);
    chk({tag, " busy_fall"}, int'(busy), 0);
  endtask

  // Watch n cycles and report whether any card_valid appeared.
  task automatic watch_no_valid(input int n, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (card_valid) seen = 1;
    end
    chk({tag, " no_valid"}, seen, 0);
  endtask

  initial begin
    int r;
    reset    = 1'b0;
    shuffle  = 1'b0;
    seed     = '0;
    deal_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst card_valid", int'(card_valid), 0);
    chk("rst card_rank", int'(card_rank), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst deck_empty", int'(deck_empty), 0);
    chk("rst deal_err", int'(deal_err), 0);
    chk("rst cards_left", int'(cards_left), 52);
    reset = 1'b1;
    @(negedge clk);

    // First deal, fold, collision, wrap, edge decodes
    deal(16'h0000, 1, 0, 1, 2, 51, "first");
    deal(16'h0037, 4, 0, 4, 2, 50, "fold55");
    deal(16'h0037, 5, 0, 5, 3, 49, "collide");
    deal(16'h0033, 13, 3, 10, 2, 48, "idx51");
    deal(16'h0033, 2, 0, 2, 4, 47, "wrap");
    deal(16'h000C, 13, 0, 10, 2, 46, "idx12");
    deal(16'h000D, 1, 1, 1, 2, 45, "idx13");

    // Fresh deck, then exhaust it with seed 0
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    chk("shuf cards_left", int'(cards_left), 52);
    chk("shuf keeps rank", int'(card_rank), 1);
    for (int i = 0; i < 52; i++) begin
      r = i % 13 + 1;
      deal(16'h0000, r, i / 13, (r > 10) ? 10 : r, 2 + i, 51 - i, "exhaust");
    end

    // Request on empty deck
    deal_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    deal_req = 1'b0;
    chk("empty deal_err", int'(deal_err), 1);
    chk("empty busy", int'(busy), 0);
    @(negedge clk);
    chk("empty deal_err pulse", int'(deal_err), 0);
    watch_no_valid(4, "empty");
    chk("empty cards_left", int'(cards_left), 0);

    // Shuffle aborting a search
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    deal(16'h0000, 1, 0, 1, 2, 51, "pre_abort");
    seed     = 16'h0000;
    deal_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    deal_req = 1'b0;
    shuffle  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    shuffle = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort cards_left", int'(cards_left), 52);
    watch_no_valid(6, "abort");

    // Shuffle and request in the same cycle
    deal_req = 1'b1;
    shuffle  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    deal_req = 1'b0;
    shuffle  = 1'b0;
    chk("drop busy", int'(busy), 0);
    watch_no_valid(5, "drop");
    chk("drop cards_left", int'(cards_left), 52);
    chk("drop keeps rank", int'(card_rank), 1);

    // Asynchronous reset mid-search
    deal(16'h0000, 1, 0, 1, 2, 51, "pre_rst");
    seed     = 16'h0000;
    deal_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    deal_req = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst busy", int'(busy), 0);
    chk("arst rank", int'(card_rank), 0);
    chk("arst suit", int'(card_suit), 0);
    chk("arst points", int'(card_points), 0);
    chk("arst cards_left", int'(cards_left), 52);
    chk("arst card_valid", int'(card_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    watch_no_valid(4, "arst");
    deal(16'h0000, 1, 0, 1, 2, 51, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
